// File: rtl/inv_cipher_ctrl.sv
// AES inverse-cipher round controller: sequences round keys, an external
// InvShiftRows/InvSubBytes datapath and an internal InvMixColumns.
// Optional macro INV_CIPHER_CTRL_ABORT_EN adds an abort input.

module inv_mix_col (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    logic [7:0] b, x2, x4, x8;
    assign b     = col_in[31-8*i -: 8];
    assign x2    = xt(b);
    assign x4    = xt(x2);
    assign x8    = xt(x4);
    assign m9[i] = x8 ^ b;
    assign mb[i] = x8 ^ x2 ^ b;
    assign md[i] = x8 ^ x4 ^ b;
    assign me[i] = x8 ^ x4 ^ x2;
  end

  // Row 0 (top byte) first; matrix rows are rotations of {0e,0b,0d,09}.
  assign col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
endmodule

module inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] dp_out,
  input  logic [127:0] dp_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
`ifdef INV_CIPHER_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  fsm_t         fsm;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic [127:0] add_key;
  logic [127:0] imc_out;
  logic         abort_hit;

  assign add_key = dp_in ^ rk_in;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_col u_imc (
      .col_in  (add_key[127-32*c -: 32]),
      .col_out (imc_out[127-32*c -: 32])
    );
  end

`ifdef INV_CIPHER_CTRL_ABORT_EN
  assign abort_hit = abort & (fsm != IDLE);
  // Abort wins over out_ready, so the block is never presented as valid that cycle.
  assign out_valid = (fsm == DONE) & ~abort;
`else
  assign abort_hit = 1'b0;
  assign out_valid = (fsm == DONE);
`endif

  // Handshakes: a block moves on the rising edge where valid && ready are both
  // high; valid never depends on ready, and ready is only offered in IDLE.
  assign in_ready = (fsm == IDLE) & ~rst;
  assign busy     = (fsm != IDLE);
  assign dp_out   = state_q;
  assign data_out = state_q;

  always_comb begin
    rk_idx = 4'd0;
    case (fsm)
      INIT:    rk_idx = NR_IDX;
      ROUND:   rk_idx = round_q;
      default: rk_idx = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm     <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else if (abort_hit) begin
      fsm     <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q <= data_in;
            round_q <= NR_IDX;
            fsm     <= INIT;
          end
        end
        INIT: begin
          state_q <= state_q ^ rk_in;
          round_q <= NR_IDX - 4'd1;
          fsm     <= ROUND;
        end
        ROUND: begin
          state_q <= imc_out;
          if (round_q != 4'd0) round_q <= round_q - 4'd1;
          if (round_q == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          state_q <= add_key;
          fsm     <= DONE;
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl: models the key schedule and the
// InvShiftRows/InvSubBytes datapath, checks FIPS-197 vectors and control timing.

module tb_inv_cipher_ctrl;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic [127:0] dp_out;
  logic [127:0] dp_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
`ifdef INV_CIPHER_CTRL_ABORT_EN
  logic         abort;
  int           hs_cnt;
`endif

  int checks;
  int failures;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk_tab   [2][16];
  logic         key_sel;
  logic         pend_sel;

  inv_cipher_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .dp_out    (dp_out),
    .dp_in     (dp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
`ifdef INV_CIPHER_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES reference models ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 16; k++) rk_tab[r][k] = '0;
  endtask

  task automatic expand_key(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
    return o;
  endfunction

  assign rk_in = rk_tab[key_sel][rk_idx];
  always_comb dp_in = inv_sr_sb(dp_out);

  // The key set for a block is latched when that block is accepted.
  always @(posedge clk) if (in_valid && in_ready) key_sel <= pend_sel;

`ifdef INV_CIPHER_CTRL_ABORT_EN
  always @(posedge clk) if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
`endif

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    in_valid = 1'b1;
    data_in  = CT_C1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    checks++; if (rk_idx !== 4'd0) begin failures++; $display("FAIL rst_rk_idx: got %0d exp 0", rk_idx); end
    checks++; if (data_out !== 128'h0) begin failures++; $display("FAIL rst_data_out: got %h exp 0", data_out); end
    checks++; if (dp_out !== 128'h0) begin failures++; $display("FAIL rst_dp_out: got %h exp 0", dp_out); end
  endtask

  task automatic test_fips_c1();
    logic [3:0] exp_rk;
    pend_sel  = 1'b0;
    in_valid  = 1'b1;
    data_in   = CT_C1;
    out_ready = 1'b0;
    rst       = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL first_edge_ready: got %b exp 1", in_ready); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      exp_rk = (i <= 11) ? 4'(11 - i) : 4'd0;
      checks++; if (rk_idx !== exp_rk) begin failures++; $display("FAIL rk_trace[%0d]: got %0d exp %0d", i, rk_idx, exp_rk); end
      checks++; if (out_valid !== (i == 12)) begin failures++; $display("FAIL c1_out_valid[%0d]: got %b exp %b", i, out_valid, (i == 12)); end
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL c1_busy[%0d]: busy %b in_ready %b exp 1/0", i, busy, in_ready); end
    end
    checks++; if (data_out !== PT_C1) begin failures++; $display("FAIL c1_data_out: got %h exp %h", data_out, PT_C1); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL c1_release: valid %b busy %b ready %b exp 0/0/1", out_valid, busy, in_ready); end
  endtask

  task automatic test_backpressure();
    pend_sel = 1'b1;
    data_in  = CT_B;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b1 || data_out !== PT_B) begin
      failures++; $display("FAIL bp_first: valid %b data %h exp 1 %h", out_valid, data_out, PT_B); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = CT_C1;
      pend_sel = 1'b0;
      checks++; if (out_valid !== 1'b1 || data_out !== PT_B || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]: valid %b ready %b data %h exp 1 0 %h", k, out_valid, in_ready, data_out, PT_B); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: busy %b valid %b ready %b exp 0/0/1", busy, out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    logic [127:0] outs [2];
    int nacc, nout;
    nacc = 0; nout = 0;
    acc[0] = 0; acc[1] = 0;
    outs[0] = '0; outs[1] = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = CT_C1;
    pend_sel  = 1'b0;
    for (int i = 0; i < 40 && nout < 2; i++) begin
      if (in_valid && in_ready && nacc < 2) begin acc[nacc] = i; nacc++; end
      if (out_valid && out_ready && nout < 2) begin outs[nout] = data_out; nout++; end
      @(negedge clk);
      if (nacc == 1) begin data_in = CT_B; pend_sel = 1'b1; end
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (nacc !== 2 || nout !== 2) begin failures++; $display("FAIL b2b_count: acc %0d out %0d exp 2 2", nacc, nout); end
    checks++; if (acc[1] - acc[0] !== 13) begin failures++; $display("FAIL b2b_interval: got %0d exp 13", acc[1] - acc[0]); end
    checks++; if (outs[0] !== PT_C1) begin failures++; $display("FAIL b2b_out0: got %h exp %h", outs[0], PT_C1); end
    checks++; if (outs[1] !== PT_B) begin failures++; $display("FAIL b2b_out1: got %h exp %h", outs[1], PT_B); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    pend_sel = 1'b1;
    data_in  = CT_B;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || rk_idx !== 4'd0 || dp_out !== 128'h0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_rst_state: busy %b valid %b rk %0d dp %h ready %b exp 0 0 0 0 0", busy, out_valid, rk_idx, dp_out, in_ready); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_output: got %b exp 0", seen); end
    pend_sel = 1'b0;
    data_in  = CT_C1;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b1 || data_out !== PT_C1) begin
      failures++; $display("FAIL mid_next_block: valid %b data %h exp 1 %h", out_valid, data_out, PT_C1); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef INV_CIPHER_CTRL_ABORT_EN
  task automatic test_abort();
    logic seen;
    int   hs_before;
    pend_sel = 1'b1;
    data_in  = CT_B;
    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || dp_out !== 128'h0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_mid: busy %b ready %b dp %h valid %b exp 0 1 0 0", busy, in_ready, dp_out, out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_output: got %b exp 0", seen); end
    pend_sel = 1'b0;
    data_in  = CT_C1;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b1 || data_out !== PT_C1) begin
      failures++; $display("FAIL abort_pre_done: valid %b data %h exp 1 %h", out_valid, data_out, PT_C1); end
    hs_before = hs_cnt;
    abort     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_done_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    checks++; if (hs_cnt !== hs_before) begin failures++; $display("FAIL abort_done_hs: got %0d exp %0d", hs_cnt, hs_before); end
    checks++; if (busy !== 1'b0 || data_out !== 128'h0) begin
      failures++; $display("FAIL abort_done_state: busy %b data %h exp 0 0", busy, data_out); end
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    key_sel   = 1'b0;
    pend_sel  = 1'b0;
`ifdef INV_CIPHER_CTRL_ABORT_EN
    abort     = 1'b0;
    hs_cnt    = 0;
`endif
    init_tables();
    expand_key(KEY_C1, 0);
    expand_key(KEY_B, 1);

    test_reset();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef INV_CIPHER_CTRL_ABORT_EN
    test_abort();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
